// File: rtl/i2c_slave_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_slave_ctrl
//  Description : I2C target with START/STOP detection, 7-bit address match,
//                write reception and read transmission. Optional SCL clock
//                stretching while no transmit byte is ready: I2C_SLV_STRETCH_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_slave_ctrl #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_out,
    output logic       scl_out,
    input  logic [7:0] data_in,
    input  logic       tx_valid,
    output logic       tx_load,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       rw,
    output logic       busy,
    output logic       nack_seen,
    output logic       stop_done
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_WRITE     = 3'd3,
        ST_WRITE_ACK = 3'd4,
        ST_READ      = 3'd5,
        ST_READ_ACK  = 3'd6
    } state_t;

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_prev;
    logic                   r_sda_prev;

    state_t     r_state;
    logic [2:0] r_cnt;
    logic [7:0] r_rx;
    logic [7:0] r_tx;
    logic       r_byte_done;
    logic       r_acked;
    logic       r_sda_out;
    logic [7:0] r_data_out;
    logic       r_valid;
    logic       r_tx_load;
    logic       r_rw;
    logic       r_busy;
    logic       r_nack_seen;
    logic       r_stop_done;

    logic       w_scl;
    logic       w_sda;
    logic       w_scl_rise;
    logic       w_scl_fall;
    logic       w_start;
    logic       w_stop;
    logic [2:0] w_cnt_dec;
    logic       w_load_point;

`ifdef I2C_SLV_STRETCH_EN
    logic r_scl_out;
    logic r_wait;
    logic r_release;
    assign scl_out = r_scl_out;
`else
    logic w_unused_tx_valid;
    assign w_unused_tx_valid = tx_valid;
    assign scl_out = 1'b1;
`endif

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise = ~r_scl_prev & w_scl;
    assign w_scl_fall = r_scl_prev & ~w_scl;
    assign w_start    = r_scl_prev & w_scl & r_sda_prev & ~w_sda;
    assign w_stop     = r_scl_prev & w_scl & ~r_sda_prev & w_sda;
    assign w_cnt_dec  = r_cnt - 3'd1;

    // Both ACK phases of a read hand over to a fresh transmit byte on the SCL fall
    assign w_load_point = w_scl_fall &
                          (((r_state == ST_ADDR_ACK) && r_rw) ||
                           ((r_state == ST_READ_ACK) && r_acked));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
            r_scl_prev <= w_scl;
            r_sda_prev <= w_sda;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 3'd7;
            r_rx        <= 8'h00;
            r_tx        <= 8'h00;
            r_byte_done <= 1'b0;
            r_acked     <= 1'b0;
            r_sda_out   <= 1'b1;
            r_data_out  <= 8'h00;
            r_valid     <= 1'b0;
            r_tx_load   <= 1'b0;
            r_rw        <= 1'b0;
            r_busy      <= 1'b0;
            r_nack_seen <= 1'b0;
            r_stop_done <= 1'b0;
`ifdef I2C_SLV_STRETCH_EN
            r_scl_out   <= 1'b1;
            r_wait      <= 1'b0;
            r_release   <= 1'b0;
`endif
        end else begin
            r_valid     <= 1'b0;
            r_tx_load   <= 1'b0;
            r_nack_seen <= 1'b0;
            r_stop_done <= 1'b0;
            if (w_stop) begin
                r_state     <= ST_IDLE;
                r_cnt       <= 3'd7;
                r_byte_done <= 1'b0;
                r_acked     <= 1'b0;
                r_sda_out   <= 1'b1;
                r_busy      <= 1'b0;
                r_stop_done <= 1'b1;
`ifdef I2C_SLV_STRETCH_EN
                r_scl_out   <= 1'b1;
                r_wait      <= 1'b0;
                r_release   <= 1'b0;
`endif
            end else if (w_start) begin
                r_state     <= ST_ADDR;
                r_cnt       <= 3'd7;
                r_byte_done <= 1'b0;
                r_acked     <= 1'b0;
                r_sda_out   <= 1'b1;
`ifdef I2C_SLV_STRETCH_EN
                r_scl_out   <= 1'b1;
                r_wait      <= 1'b0;
                r_release   <= 1'b0;
`endif
            end else begin
                case (r_state)
                    ST_ADDR, ST_WRITE: begin
                        if (w_scl_rise) begin
                            r_rx <= {r_rx[6:0], w_sda};
                            if (r_cnt != 3'd0) r_cnt <= w_cnt_dec;
                            else               r_byte_done <= 1'b1;
                        end else if (w_scl_fall && r_byte_done) begin
                            r_byte_done <= 1'b0;
                            if (r_state == ST_WRITE) begin
                                r_data_out <= r_rx;
                                r_valid    <= 1'b1;
                                r_state    <= ST_WRITE_ACK;
                                r_sda_out  <= 1'b0;
                            end else if (r_rx[7:1] == SLAVE_ADDR) begin
                                r_state   <= ST_ADDR_ACK;
                                r_sda_out <= 1'b0;
                                r_rw      <= r_rx[0];
                                r_busy    <= 1'b1;
                            end else begin
                                r_state   <= ST_IDLE;
                                r_sda_out <= 1'b1;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (w_scl_fall) begin
                            r_cnt <= 3'd7;
                            if (r_rw) begin
                                r_state <= ST_READ;
                            end else begin
                                r_state   <= ST_WRITE;
                                r_sda_out <= 1'b1;
                            end
                        end
                    end
                    ST_WRITE_ACK: begin
                        if (w_scl_fall) begin
                            r_state   <= ST_WRITE;
                            r_sda_out <= 1'b1;
                            r_cnt     <= 3'd7;
                        end
                    end
                    ST_READ: begin
                        if (w_scl_fall) begin
                            if (r_cnt != 3'd0) begin
                                r_sda_out <= r_tx[w_cnt_dec];
                                r_cnt     <= w_cnt_dec;
                            end else begin
                                r_state   <= ST_READ_ACK;
                                r_sda_out <= 1'b1;
                            end
                        end
                    end
                    ST_READ_ACK: begin
                        if (w_scl_rise) begin
                            if (w_sda) begin
                                r_nack_seen <= 1'b1;
                                r_state     <= ST_IDLE;
                                r_busy      <= 1'b0;
                            end else begin
                                r_acked <= 1'b1;
                            end
                        end else if (w_scl_fall && r_acked) begin
                            r_acked <= 1'b0;
                            r_state <= ST_READ;
                            r_cnt   <= 3'd7;
                        end
                    end
                    default: ;
                endcase

                if (w_load_point) begin
`ifdef I2C_SLV_STRETCH_EN
                    if (tx_valid) begin
                        r_tx      <= data_in;
                        r_sda_out <= data_in[7];
                        r_tx_load <= 1'b1;
                    end else begin
                        r_scl_out <= 1'b0;
                        r_wait    <= 1'b1;
                    end
`else
                    r_tx      <= data_in;
                    r_sda_out <= data_in[7];
                    r_tx_load <= 1'b1;
`endif
                end

`ifdef I2C_SLV_STRETCH_EN
                // SCL is released one clk after the late byte lands so SDA is already settled
                if (r_wait && tx_valid) begin
                    r_tx      <= data_in;
                    r_sda_out <= data_in[7];
                    r_tx_load <= 1'b1;
                    r_wait    <= 1'b0;
                    r_release <= 1'b1;
                end
                if (r_release) begin
                    r_scl_out <= 1'b1;
                    r_release <= 1'b0;
                end
`endif
            end
        end
    end

    assign sda_out   = r_sda_out;
    assign data_out  = r_data_out;
    assign valid     = r_valid;
    assign tx_load   = r_tx_load;
    assign rw        = r_rw;
    assign busy      = r_busy;
    assign nack_seen = r_nack_seen;
    assign stop_done = r_stop_done;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_i2c_slave_ctrl
//  Description : Bus-level master model driving i2c_slave_ctrl at 100 kHz SCL.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_slave_ctrl;

    localparam int c_quarter = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       tx_valid = 1'b0;

    logic       sda_out;
    logic       scl_out;
    logic       tx_load;
    logic [7:0] data_out;
    logic       valid;
    logic       rw;
    logic       busy;
    logic       nack_seen;
    logic       stop_done;
    logic       scl_line;
    logic       sda_line;

    assign scl_line = scl_m & scl_out;
    assign sda_line = sda_m & sda_out;

    always #125 clk = ~clk;

    i2c_slave_ctrl #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .scl_in(scl_line), .sda_in(sda_line),
        .sda_out(sda_out), .scl_out(scl_out), .data_in(data_in),
        .tx_valid(tx_valid), .tx_load(tx_load), .data_out(data_out),
        .valid(valid), .rw(rw), .busy(busy), .nack_seen(nack_seen),
        .stop_done(stop_done)
    );

    int         n_valid = 0, n_load = 0, n_nack = 0, n_stop = 0;
    int         n_sda_low = 0, n_busy = 0, n_scl_low = 0;
    logic [7:0] vq[$];

    always @(negedge clk) begin
        if (valid) begin
            n_valid++;
            vq.push_back(data_out);
        end
        if (tx_load)   n_load++;
        if (nack_seen) n_nack++;
        if (stop_done) n_stop++;
        if (!sda_out)  n_sda_low++;
        if (busy)      n_busy++;
        if (!scl_out)  n_scl_low++;
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic q();
        repeat (c_quarter) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, output logic s);
        int k;
        sda_m = b;
        q();
        scl_m = 1'b1;
        q();
        k = 0;
        while (!scl_line && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 2000) chk("scl_release_timeout", 32'd0, 32'd1);
        s = sda_line;
        q();
        scl_m = 1'b0;
        q();
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        q();
        scl_m = 1'b1;
        q();
        sda_m = 1'b0;
        q();
        scl_m = 1'b0;
        q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        q();
        scl_m = 1'b1;
        q();
        sda_m = 1'b1;
        q();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) send_bit(b[i], s);
        send_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_bits(output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, s);
            d[i] = s;
        end
    endtask

    typedef struct {
        logic [7:0] addr;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       exp_ack;
        int         exp_nvalid;
        logic [7:0] exp_v0;
        logic [7:0] exp_v1;
    } wvec_t;

    wvec_t tbl[4];

    initial begin
        #50_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ack;
        logic       s;
        logic [7:0] d;
        int         b_valid, b_stop, b_low, b_busy, b_load, b_nack, b_scl, vbase, cnt;

        tbl[0] = '{8'hA0, 8'h3C, 8'hF1, 1'b1, 2, 8'h3C, 8'hF1};
        tbl[1] = '{8'hA2, 8'h55, 8'h55, 1'b0, 0, 8'h00, 8'h00};
        tbl[2] = '{8'hA0, 8'h00, 8'hFF, 1'b1, 2, 8'h00, 8'hFF};
        tbl[3] = '{8'h50, 8'hAA, 8'hAA, 1'b0, 0, 8'h00, 8'h00};

        repeat (3) @(negedge clk);
        chk("rst_sda_out", sda_out, 1);
        chk("rst_scl_out", scl_out, 1);
        chk("rst_data_out", data_out, 8'h00);
        chk("rst_pulses", {valid, tx_load, nack_seen, stop_done}, 4'b0000);
        chk("rst_rw_busy", {rw, busy}, 2'b00);
        rst_n = 1'b1;
        q();

        for (int i = 0; i < 4; i++) begin
            b_valid = n_valid; b_stop = n_stop; b_low = n_sda_low; b_busy = n_busy;
            vbase = vq.size();
            i2c_start();
            send_byte(tbl[i].addr, ack);
            chk("wr_addr_ack", ack, tbl[i].exp_ack);
            send_byte(tbl[i].d0, ack);
            chk("wr_d0_ack", ack, tbl[i].exp_ack);
            chk("wr_busy_mid", busy, tbl[i].exp_ack);
            send_byte(tbl[i].d1, ack);
            chk("wr_d1_ack", ack, tbl[i].exp_ack);
            if (tbl[i].exp_ack) chk("wr_rw", rw, 0);
            i2c_stop();
            q();
            chk("wr_valid_count", n_valid - b_valid, tbl[i].exp_nvalid);
            if (tbl[i].exp_nvalid == 2) begin
                chk("wr_data0", vq[vbase], tbl[i].exp_v0);
                chk("wr_data1", vq[vbase+1], tbl[i].exp_v1);
            end
            chk("wr_stop_count", n_stop - b_stop, 1);
            chk("wr_busy_after", busy, 0);
            if (!tbl[i].exp_ack) begin
                chk("mis_sda_never_low", n_sda_low - b_low, 0);
                chk("mis_busy_never", n_busy - b_busy, 0);
            end
        end

        // Read of two bytes: ACK then NACK
        b_load = n_load; b_nack = n_nack; b_stop = n_stop;
        tx_valid = 1'b1;
        data_in  = 8'h96;
        i2c_start();
        send_byte(8'hA1, ack);
        chk("rd_addr_ack", ack, 1);
        chk("rd_rw", rw, 1);
        read_bits(d);
        chk("rd_byte0", d, 8'h96);
        data_in = 8'h5A;
        send_bit(1'b0, s);
        read_bits(d);
        chk("rd_byte1", d, 8'h5A);
        send_bit(1'b1, s);
        q();
        chk("rd_busy_after_nack", busy, 0);
        chk("rd_sda_released", sda_out, 1);
        i2c_stop();
        q();
        chk("rd_tx_load_count", n_load - b_load, 2);
        chk("rd_nack_count", n_nack - b_nack, 1);
        chk("rd_stop_count", n_stop - b_stop, 1);

        // Write then repeated START into a read
        b_valid = n_valid;
        vbase   = vq.size();
        data_in = 8'hC3;
        i2c_start();
        send_byte(8'hA0, ack);
        chk("sr_addr_w_ack", ack, 1);
        send_byte(8'h10, ack);
        chk("sr_data_ack", ack, 1);
        chk("sr_rw_before", rw, 0);
        i2c_start();
        send_byte(8'hA1, ack);
        chk("sr_addr_r_ack", ack, 1);
        chk("sr_rw_after", rw, 1);
        read_bits(d);
        chk("sr_read_byte", d, 8'hC3);
        send_bit(1'b1, s);
        i2c_stop();
        q();
        chk("sr_valid_count", n_valid - b_valid, 1);
        if (n_valid - b_valid == 1) chk("sr_valid_data", vq[vbase], 8'h10);

        // Reset while the target holds SDA low for a write ACK
        i2c_start();
        send_byte(8'hA0, ack);
        chk("rst_mid_addr_ack", ack, 1);
        for (int i = 7; i >= 0; i--) send_bit(1'b0, s);
        sda_m = 1'b1;
        q();
        chk("rst_mid_sda_low", sda_out, 0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_sda_async", sda_out, 1);
        chk("rst_mid_busy", busy, 0);
        q();
        rst_n = 1'b1;
        q();
        i2c_start();
        send_byte(8'hA0, ack);
        chk("rst_after_ack", ack, 1);
        i2c_stop();
        q();

`ifdef I2C_SLV_STRETCH_EN
        b_load   = n_load;
        tx_valid = 1'b0;
        data_in  = 8'h37;
        i2c_start();
        send_byte(8'hA1, ack);
        chk("st_addr_ack", ack, 1);
        repeat (5) @(negedge clk);
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!scl_out) cnt++;
        end
        chk("st_scl_held", cnt, 50);
        tx_valid = 1'b1;
        @(negedge clk);
        chk("st_scl_still_low", scl_out, 0);
        chk("st_sda_bit7", sda_out, 0);
        @(negedge clk);
        chk("st_scl_released", scl_out, 1);
        read_bits(d);
        chk("st_byte", d, 8'h37);
        send_bit(1'b1, s);
        i2c_stop();
        q();
        chk("st_tx_load_count", n_load - b_load, 1);
`else
        b_load   = n_load;
        b_scl    = n_scl_low;
        tx_valid = 1'b0;
        data_in  = 8'h37;
        i2c_start();
        send_byte(8'hA1, ack);
        chk("ns_addr_ack", ack, 1);
        read_bits(d);
        chk("ns_byte", d, 8'h37);
        send_bit(1'b1, s);
        i2c_stop();
        q();
        chk("ns_scl_never_low", n_scl_low - b_scl, 0);
        chk("ns_tx_load_count", n_load - b_load, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
